call_stack: RTL and testbench

Hardware call/return stack that sits directly upstream of the iteration counter stage. On a CALL it saves the return address and the callee's 16-bit iteration count. On a RET it pops the top entry and presents the return address and count to the downstream stage, along with a one-cycle strobe that drives that stage's return-enable input. It also reports occupancy and overflow/underflow conditions to the control unit.

---
 rtl/arch_pkg.sv | 13 +
 rtl/call_stack_mem.sv | 18 +
 rtl/call_stack.sv | 80 ++++++++
 tb/tb_call_stack.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/arch_pkg.sv
// arch_pkg: shared widths, stack entry type and control-unit stack-op encoding.
package arch_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [CNT_W_DEF-1:0]  cnt;
  } stack_entry_t;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} stack_op_t;
  function automatic stack_op_t to_op(input logic push, input logic pop);
    return push ? (pop ? OP_REPLACE : OP_PUSH) : (pop ? OP_POP : OP_NONE);
  endfunction
endpackage

// File: rtl/call_stack_mem.sv
// call_stack_mem: DEPTH x W register array, one synchronous write port, one asynchronous read port.
module call_stack_mem #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack.sv
// call_stack: hardware CALL/RET stack feeding the iteration counter stage.
// Define CALL_STACK_ERR_EN for sticky overflow/underflow flags; otherwise they are tied to 0.
module call_stack
  import arch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic              pop,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [CNT_W-1:0]  ret_cnt,
  output logic              ret_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [CNT_W-1:0]  top_cnt,
  output logic [LW-1:0]     level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = ADDR_W + CNT_W;
  logic [LW-1:0] sp;
  logic [W-1:0] rd;
  logic [AW-1:0] wr_idx, rd_idx;
  logic do_push, do_pop, replace, ovf_evt, udf_evt;
  stack_op_t op;
  assign op = to_op(push, pop);
  assign level = sp;
  assign empty = sp == '0;
  assign full = sp == LW'(DEPTH);
  assign top_addr = empty ? '0 : rd[W-1:CNT_W];
  assign top_cnt = empty ? '0 : rd[CNT_W-1:0];
  always_comb begin
    do_pop = (op == OP_POP || op == OP_REPLACE) && !empty;
    do_push = op == OP_REPLACE || (op == OP_PUSH && !full);
    replace = op == OP_REPLACE && !empty;
    ovf_evt = op == OP_PUSH && full;
    udf_evt = (op == OP_POP || op == OP_REPLACE) && empty;
    rd_idx = AW'(sp - LW'(1));
    wr_idx = replace ? rd_idx : AW'(sp);
  end
  call_stack_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk(clk), .we(do_push), .waddr(wr_idx), .wdata({push_addr, push_cnt}),
    .raddr(rd_idx), .rdata(rd)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sp <= '0;
      ret_valid <= 1'b0;
      ret_addr <= '0;
      ret_cnt <= '0;
    end else begin
      sp <= (do_push && !do_pop) ? sp + LW'(1) : (do_pop && !do_push) ? sp - LW'(1) : sp;
      ret_valid <= do_pop;
      if (do_pop) {ret_addr, ret_cnt} <= rd;
    end
`ifdef CALL_STACK_ERR_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= overflow | ovf_evt;
      underflow <= underflow | udf_evt;
    end
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
  logic unused_evt;
  assign unused_evt = ovf_evt ^ udf_evt;
`endif
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed self-checking bench for call_stack (DEPTH=8, 16-bit fields).
module tb_call_stack;
  import arch_pkg::*;
`ifdef CALL_STACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, push = 1'b0, pop = 1'b0;
  logic [15:0] push_addr = '0, push_cnt = '0;
  logic [15:0] ret_addr, ret_cnt, top_addr, top_cnt;
  logic [3:0] level;
  logic ret_valid, empty, full, overflow, underflow;
  int checks = 0, errors = 0;

  call_stack #(.DEPTH(8), .ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .push(push), .push_addr(push_addr), .push_cnt(push_cnt),
    .pop(pop), .ret_addr(ret_addr), .ret_cnt(ret_cnt), .ret_valid(ret_valid),
    .top_addr(top_addr), .top_cnt(top_cnt), .level(level), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic p, input logic q, input logic [15:0] a, input logic [15:0] c);
    push = p; pop = q; push_addr = a; push_cnt = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b exp 10", empty, full); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL reset_ret_valid: got %b exp 0", ret_valid); end
    checks++; if ({ret_addr, ret_cnt} !== 32'h0) begin errors++; $display("FAIL reset_ret: got %h exp 0", {ret_addr, ret_cnt}); end
    checks++; if ({top_addr, top_cnt} !== 32'h0) begin errors++; $display("FAIL reset_top: got %h exp 0", {top_addr, top_cnt}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {overflow, underflow}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_lifo;
    cyc(1, 0, 16'h0010, 16'd3);
    cyc(1, 0, 16'h0020, 16'd5);
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL lifo_level: got %0d exp 2", level); end
    checks++; if ({top_addr, top_cnt} !== {16'h0020, 16'd5}) begin errors++; $display("FAIL lifo_top: got %h exp 00200005", {top_addr, top_cnt}); end
    cyc(0, 1, 0, 0);
    checks++; if ({ret_valid, ret_addr, ret_cnt} !== {1'b1, 16'h0020, 16'd5}) begin errors++; $display("FAIL lifo_pop1: got %b %h %h exp 1 0020 0005", ret_valid, ret_addr, ret_cnt); end
    cyc(0, 1, 0, 0);
    checks++; if ({ret_valid, ret_addr, ret_cnt} !== {1'b1, 16'h0010, 16'd3}) begin errors++; $display("FAIL lifo_pop2: got %b %h %h exp 1 0010 0003", ret_valid, ret_addr, ret_cnt); end
    cyc(0, 0, 0, 0);
    checks++; if ({ret_valid, empty, ret_addr} !== {1'b0, 1'b1, 16'h0010}) begin errors++; $display("FAIL lifo_after: got %b %b %h exp 0 1 0010", ret_valid, empty, ret_addr); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 16'h0100 + 16'(i), 16'(i));
      if (i == 7) begin
        checks++; if ({full, level} !== {1'b1, 4'd8}) begin errors++; $display("FAIL ovf_full8: got %b %0d exp 1 8", full, level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", overflow); end
      end
    end
    checks++; if ({full, level} !== {1'b1, 4'd8}) begin errors++; $display("FAIL ovf_level9: got %b %0d exp 1 8", full, level); end
    checks++; if ({top_addr, top_cnt} !== {16'h0107, 16'd7}) begin errors++; $display("FAIL ovf_top: got %h exp 01070007", {top_addr, top_cnt}); end
    checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag: got %b exp %b", overflow, ERR_EN); end
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 1, 0, 0);
      checks++; if ({ret_valid, ret_addr, ret_cnt} !== {1'b1, 16'h0100 + 16'(i), 16'(i)}) begin errors++; $display("FAIL ovf_pop%0d: got %b %h %h", i, ret_valid, ret_addr, ret_cnt); end
    end
    cyc(0, 0, 0, 0);
    checks++; if ({ret_valid, empty, overflow} !== {1'b0, 1'b1, ERR_EN}) begin errors++; $display("FAIL ovf_end: got %b %b %b exp 0 1 %b", ret_valid, empty, overflow, ERR_EN); end
  endtask

  task automatic test_underflow;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_pre: got %b exp 0", underflow); end
    cyc(0, 1, 0, 0);
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL udf_valid: got %b exp 0", ret_valid); end
    checks++; if ({ret_addr, ret_cnt} !== {16'h0100, 16'd0}) begin errors++; $display("FAIL udf_hold: got %h exp 01000000", {ret_addr, ret_cnt}); end
    checks++; if ({underflow, level} !== {ERR_EN, 4'd0}) begin errors++; $display("FAIL udf_flag: got %b %0d exp %b 0", underflow, level, ERR_EN); end
  endtask

  task automatic test_replace;
    cyc(1, 0, 16'h0030, 16'd2);
    cyc(1, 1, 16'h0040, 16'd7);
    checks++; if ({ret_valid, ret_addr, ret_cnt} !== {1'b1, 16'h0030, 16'd2}) begin errors++; $display("FAIL rep_ret: got %b %h %h exp 1 0030 0002", ret_valid, ret_addr, ret_cnt); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL rep_level: got %0d exp 1", level); end
    checks++; if ({top_addr, top_cnt} !== {16'h0040, 16'd7}) begin errors++; $display("FAIL rep_top: got %h exp 00400007", {top_addr, top_cnt}); end
    cyc(0, 1, 0, 0);
    checks++; if ({ret_valid, ret_addr, ret_cnt, empty} !== {1'b1, 16'h0040, 16'd7, 1'b1}) begin errors++; $display("FAIL rep_pop: got %b %h %h %b", ret_valid, ret_addr, ret_cnt, empty); end
    cyc(1, 1, 16'h0070, 16'd9);
    checks++; if ({ret_valid, level, top_addr, top_cnt} !== {1'b0, 4'd1, 16'h0070, 16'd9}) begin errors++; $display("FAIL rep_empty: got %b %0d %h %h", ret_valid, level, top_addr, top_cnt); end
    checks++; if ({ret_addr, underflow} !== {16'h0040, ERR_EN}) begin errors++; $display("FAIL rep_empty_hold: got %h %b exp 0040 %b", ret_addr, underflow, ERR_EN); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_zero_cnt;
    cyc(1, 0, 16'h0050, 16'd0);
    cyc(0, 1, 0, 0);
    checks++; if ({ret_valid, ret_addr, ret_cnt} !== {1'b1, 16'h0050, 16'd0}) begin errors++; $display("FAIL zero_ret: got %b %h %h exp 1 0050 0000", ret_valid, ret_addr, ret_cnt); end
    cyc(0, 0, 0, 0);
    checks++; if ({ret_valid, ret_addr} !== {1'b0, 16'h0050}) begin errors++; $display("FAIL zero_once: got %b %h exp 0 0050", ret_valid, ret_addr); end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 16'h0060, 16'd1);
    cyc(1, 0, 16'h0061, 16'd2);
    cyc(1, 0, 16'h0062, 16'd3);
    pop = 1'b1;
    #3 reset = 1'b1;
    #1;
    checks++; if ({level, empty, ret_valid} !== {4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL rmid_state: got %0d %b %b exp 0 1 0", level, empty, ret_valid); end
    checks++; if ({overflow, underflow, ret_addr} !== {2'b00, 16'h0}) begin errors++; $display("FAIL rmid_clear: got %b%b %h exp 00 0000", overflow, underflow, ret_addr); end
    @(posedge clk); #1;
    checks++; if ({ret_valid, level} !== {1'b0, 4'd0}) begin errors++; $display("FAIL rmid_edge: got %b %0d exp 0 0", ret_valid, level); end
    pop = 1'b0;
    @(negedge clk); reset = 1'b0;
    cyc(1, 0, 16'h0080, 16'd4);
    cyc(0, 1, 0, 0);
    checks++; if (ret_valid !== 1'b1) begin errors++; $display("FAIL rmid_strobe: got %b exp 1", ret_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({ret_valid, ret_addr} !== {1'b0, 16'h0}) begin errors++; $display("FAIL rmid_cancel: got %b %h exp 0 0000", ret_valid, ret_addr); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_lifo;
    test_overflow;
    test_underflow;
    test_replace;
    test_zero_cnt;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
